// File: rtl/dram_refresh_scheduler.sv
// rtl/dram_refresh_scheduler.sv - CAS-before-RAS refresh generator with queued refresh debt
module dram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 108,
  parameter int MAX_PENDING      = 4,
  parameter int RAS_WIDTH        = 2,
  parameter int PRECHARGE        = 2
) (
  input  logic                               CLK,
  input  logic                               RESETn,
  input  logic                               ASn,
  input  logic                               ACCESS_ACTIVE,
  output logic                               REF_CAS,
  output logic                               REF_RAS,
  output logic                               REF_BUSY,
  output logic [$clog2(MAX_PENDING+1)-1:0]   PENDING,
  output logic                               OVERFLOW
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int PH_MAX = (RAS_WIDTH > PRECHARGE) ? RAS_WIDTH : PRECHARGE;
  localparam int CW = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [PW-1:0] PEND_MAX     = PW'(MAX_PENDING);
  localparam logic [CW-1:0] RAS_LAST     = CW'(RAS_WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST     = CW'(PRECHARGE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CAS_SETUP = 2'd1;
  localparam logic [1:0] S_RAS_ON    = 2'd2;
  localparam logic [1:0] S_PRECHARGE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_phase;
  logic [CW-1:0] w_next_phase;
  logic [PW-1:0] r_pending;
  logic          r_overflow;
  logic          r_cas;
  logic          r_ras;
  logic          r_busy;
  logic          w_tick;
  logic          w_start_cond;
  logic          w_pre_done;
  logic          w_start;

  assign w_tick       = (r_timer == '0);
  assign w_start_cond = (r_pending != '0) && ASn && !ACCESS_ACTIVE;
  assign w_pre_done   = (r_state == S_PRECHARGE) && (r_phase == PRE_LAST);
  // A refresh may only begin from IDLE or from the last precharge cycle (burst).
  assign w_start      = w_start_cond && ((r_state == S_IDLE) || w_pre_done);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_timer <= TIMER_RELOAD;
    end else if (w_tick) begin
      r_timer <= TIMER_RELOAD;
    end else begin
      r_timer <= r_timer - TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_tick, w_start})
        2'b10: begin
          if (r_pending == PEND_MAX) begin
            r_overflow <= 1'b1;
          end else begin
            r_pending <= r_pending + PW'(1);
          end
        end
        2'b01:   r_pending <= r_pending - PW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next_state = S_CAS_SETUP;
        end
      end
      S_CAS_SETUP: begin
        w_next_state = S_RAS_ON;
        w_next_phase = '0;
      end
      S_RAS_ON: begin
        if (r_phase == RAS_LAST) begin
          w_next_state = S_PRECHARGE;
          w_next_phase = '0;
        end else begin
          w_next_phase = r_phase + CW'(1);
        end
      end
      S_PRECHARGE: begin
        if (r_phase == PRE_LAST) begin
          w_next_state = w_start ? S_CAS_SETUP : S_IDLE;
          w_next_phase = '0;
        end else begin
          w_next_phase = r_phase + CW'(1);
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_phase = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they change on the transition edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_cas   <= 1'b0;
      r_ras   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
      r_cas   <= (w_next_state == S_CAS_SETUP) || (w_next_state == S_RAS_ON);
      r_ras   <= (w_next_state == S_RAS_ON);
      r_busy  <= (w_next_state != S_IDLE);
    end
  end

  assign REF_CAS  = r_cas;
  assign REF_RAS  = r_ras;
  assign REF_BUSY = r_busy;
  assign PENDING  = r_pending;
  assign OVERFLOW = r_overflow;

endmodule
